// File: rtl/multi_clock_divider_pkg.sv
// multi_clock_divider_pkg
// Shared definitions for the multi-channel clock divider:
//   ch_w()          - width of the channel-select field, at least one bit
//   DEFAULT_CNT_W   - default width of the counter / half-period registers
//   cnt_t           - counter type at the default width
//   MIN_HALF_PERIOD - smallest legal half-period; a requested 0 becomes this
package multi_clock_divider_pkg;

  localparam int DEFAULT_CNT_W   = 24;
  localparam int MIN_HALF_PERIOD = 1;

  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

  // Channel-select width: $clog2 returns 0 for a single channel, which would
  // produce a zero-width port, so clamp to one bit.
  function automatic int ch_w(input int num_ch);
    int w;
    w = $clog2(num_ch);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// multi_clock_divider_if
// Valid/ready configuration port of the clock divider.
//   cfg_valid       - request valid (master -> slave)
//   cfg_ready       - request accepted this cycle (slave -> master)
//   cfg_ch          - target channel
//   cfg_half_period - new half-period in clk_in cycles
// Modports: master (requester), slave (divider).
interface multi_clock_divider_if
  import multi_clock_divider_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEFAULT_CNT_W
);

  localparam int CH_W = ch_w(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half_period;

  modport master (output cfg_valid, output cfg_ch, output cfg_half_period, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_half_period, output cfg_ready);

endinterface

// File: rtl/multi_clock_divider_ch.sv
// clock_divider_ch
// One divider channel: 50%-duty output with a runtime half-period. A newly
// loaded half-period is staged and only takes effect at a period boundary,
// when the channel is disabled, or on a restart, so no runt pulse is produced.
// Ports:
//   clk_in, rst_n  - clock, synchronous active-low reset
//   en             - run enable (low holds the output at 0)
//   sync_restart   - realign: count and output cleared
//   load           - stage load_value (already saturated to >= 1)
//   load_value     - half-period to stage
//   clk_out        - divided clock, registered
//   pending        - a staged value is waiting to be applied
//   tick           - (MULTI_CLOCK_DIVIDER_TICK_EN only) one-cycle pulse on
//                    each rising edge of clk_out
module clock_divider_ch
  import multi_clock_divider_pkg::*;
#(
  parameter int CNT_W               = DEFAULT_CNT_W,
  parameter int DEFAULT_HALF_PERIOD = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_restart,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             clk_out,
  output logic             pending
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
  ,
  output logic             tick
`endif
);

  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] staged;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] active_next;
  logic [CNT_W-1:0] staged_next;
  logic             clk_next;
  logic             pending_next;
  logic             terminal;
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
  logic             tick_next;
`endif

  // active is never below 1, so active-1 cannot underflow.
  assign terminal = (count == (active - CNT_ONE));

  // Next-state: restart/disable beats terminal count; a load in the same
  // cycle is staged after the boundary decision so it waits for the next one.
  always_comb begin
    count_next   = count;
    active_next  = active;
    staged_next  = staged;
    clk_next     = clk_out;
    pending_next = pending;
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
    tick_next    = 1'b0;
`endif
    if (sync_restart || !en) begin
      count_next   = CNT_ZERO;
      clk_next     = 1'b0;
      active_next  = pending ? staged : active;
      pending_next = 1'b0;
    end else if (terminal) begin
      count_next   = CNT_ZERO;
      clk_next     = ~clk_out;
      active_next  = pending ? staged : active;
      pending_next = 1'b0;
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
      tick_next    = ~clk_out;
`endif
    end else begin
      count_next = count + CNT_ONE;
    end

    if (load) begin
      staged_next  = load_value;
      pending_next = 1'b1;
    end else begin
      staged_next = staged;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      count   <= CNT_ZERO;
      active  <= RESET_HALF;
      staged  <= RESET_HALF;
      clk_out <= 1'b0;
      pending <= 1'b0;
    end else begin
      count   <= count_next;
      active  <= active_next;
      staged  <= staged_next;
      clk_out <= clk_next;
      pending <= pending_next;
    end
  end

`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
  // Rising-edge marker register.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      tick <= 1'b0;
    end else begin
      tick <= tick_next;
    end
  end
`endif

endmodule

// File: rtl/multi_clock_divider.sv
// multi_clock_divider
// NUM_CH independent 50%-duty clock dividers driven from clk_in, each with a
// half-period programmable through a valid/ready config port. This level only
// decodes the config request, forms cfg_ready and fans out sync_restart.
// Optional feature macro: MULTI_CLOCK_DIVIDER_TICK_EN adds the tick output.
// Ports:
//   clk_in, rst_n  - clock, synchronous active-low reset
//   en[NUM_CH]     - per-channel run enable
//   sync_restart   - one-cycle pulse realigning all channels
//   cfg            - config port (slave): cfg_valid/cfg_ready/cfg_ch/cfg_half_period
//   clk_out        - divided clocks, registered
//   pending        - per-channel staged value not yet applied
//   tick           - (macro only) one-cycle pulse per rising clk_out
module multi_clock_divider
  import multi_clock_divider_pkg::*;
#(
  parameter int NUM_CH              = 4,
  parameter int CNT_W               = DEFAULT_CNT_W,
  parameter int DEFAULT_HALF_PERIOD = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    en,
  input  logic                 sync_restart,
  multi_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    pending
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
  ,
  output logic [NUM_CH-1:0]    tick
`endif
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] load;
  logic              ready;
  logic              accept;
  logic [CNT_W-1:0]  load_value;

  // An out-of-range channel matches nothing, so it is always ready and the
  // transfer is absorbed without touching any channel.
  assign ready         = ~|(hit & pending);
  assign cfg.cfg_ready = ready;
  assign accept        = cfg.cfg_valid & ready;
  assign load_value    = (cfg.cfg_half_period == {CNT_W{1'b0}}) ?
                         CNT_W'(MIN_HALF_PERIOD) : cfg.cfg_half_period;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign hit[g]  = (cfg.cfg_ch == CH_W'(g));
    assign load[g] = accept & hit[g];

    clock_divider_ch #(
      .CNT_W               (CNT_W),
      .DEFAULT_HALF_PERIOD (DEFAULT_HALF_PERIOD)
    ) u_ch (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .en           (en[g]),
      .sync_restart (sync_restart),
      .load         (load[g]),
      .load_value   (load_value),
      .clk_out      (clk_out[g]),
      .pending      (pending[g])
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
      ,
      .tick         (tick[g])
`endif
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: a cycle model of the channel
// rules produces the expected outputs, which are queued when each cycle's
// stimulus is driven and compared after the clock edge; directed checks cover
// boundary timing (restart rise times, collision, enable drop, reset).
module tb_multi_clock_divider;
  import multi_clock_divider_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;
  localparam int DHP    = 1;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              sync_restart;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] tick_obs;
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
  logic [NUM_CH-1:0] tick;
  assign tick_obs = tick;
`else
  assign tick_obs = 4'h0;
`endif

  multi_clock_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

  multi_clock_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF_PERIOD(DHP)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .en           (en),
    .sync_restart (sync_restart),
    .cfg          (cfg_if),
    .clk_out      (clk_out),
    .pending      (pending)
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
    ,
    .tick         (tick)
`endif
  );

  // Second instance with three channels, so that cfg_ch can name a channel
  // that does not exist.
  logic       rst3_n;
  logic [2:0] en3;
  logic       rs3;
  logic [2:0] clk_out3;
  logic [2:0] pending3;
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
  logic [2:0] tick3;
`endif

  multi_clock_divider_if #(.NUM_CH(3), .CNT_W(CNT_W)) cfg3_if ();

  multi_clock_divider #(.NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_HALF_PERIOD(DHP)) dut3 (
    .clk_in       (clk_in),
    .rst_n        (rst3_n),
    .en           (en3),
    .sync_restart (rs3),
    .cfg          (cfg3_if),
    .clk_out      (clk_out3),
    .pending      (pending3)
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
    ,
    .tick         (tick3)
`endif
  );

  typedef struct {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] tck;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  int                m_cnt [NUM_CH];
  int                m_act [NUM_CH];
  int                m_stg [NUM_CH];
  logic [NUM_CH-1:0] m_clk;
  logic [NUM_CH-1:0] m_pend;
  logic [NUM_CH-1:0] m_tick;

  int rise [NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step();
    int   sel;
    int   hp;
    logic exp_ready;
    logic accept;
    exp_t e;
    #1;
    sel = int'(cfg_if.cfg_ch);
    hp  = int'(cfg_if.cfg_half_period);
    exp_ready = (sel < NUM_CH) ? !m_pend[sel] : 1'b1;
    if (rst_n) check("cfg_ready", {31'd0, cfg_if.cfg_ready}, {31'd0, exp_ready});
    accept = cfg_if.cfg_valid && exp_ready;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        m_cnt[i] = 0; m_act[i] = DHP; m_stg[i] = DHP;
        m_clk[i] = 1'b0; m_pend[i] = 1'b0; m_tick[i] = 1'b0;
      end else begin
        m_tick[i] = 1'b0;
        if (sync_restart || !en[i]) begin
          m_cnt[i] = 0;
          m_clk[i] = 1'b0;
          if (m_pend[i]) m_act[i] = m_stg[i];
          m_pend[i] = 1'b0;
        end else if (m_cnt[i] == m_act[i] - 1) begin
          m_cnt[i] = 0;
          if (!m_clk[i]) m_tick[i] = 1'b1;
          m_clk[i] = !m_clk[i];
          if (m_pend[i]) m_act[i] = m_stg[i];
          m_pend[i] = 1'b0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
        if (accept && sel == i) begin
          m_stg[i]  = (hp == 0) ? 1 : hp;
          m_pend[i] = 1'b1;
        end
      end
    end
    e.clk = m_clk; e.pend = m_pend; e.tck = m_tick;
    sb.push_back(e);
    @(posedge clk_in);
    #1;
    e = sb.pop_front();
    check("clk_out", {28'd0, clk_out}, {28'd0, e.clk});
    check("pending", {28'd0, pending}, {28'd0, e.pend});
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
    check("tick", {28'd0, tick_obs}, {28'd0, e.tck});
`endif
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic cfg_write(input int ch, input int v);
    cfg_if.cfg_valid       = 1'b1;
    cfg_if.cfg_ch          = 2'(ch);
    cfg_if.cfg_half_period = 24'(v);
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Cycles until each channel's first rising clk_out (0 = no rise within n cycles).
  task automatic rise_scan(input int n);
    for (int i = 0; i < NUM_CH; i++) rise[i] = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      for (int i = 0; i < NUM_CH; i++)
        if (rise[i] == 0 && clk_out[i]) rise[i] = k;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int pc;
    int found;
    rst_n = 1'b0; en = 4'hF; sync_restart = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_half_period = 24'd0;
    rst3_n = 1'b0; en3 = 3'h0; rs3 = 1'b0;
    cfg3_if.cfg_valid = 1'b0; cfg3_if.cfg_ch = 2'd0; cfg3_if.cfg_half_period = 24'd0;

    // reset for 3 cycles, then default half-period 1: toggle every cycle
    cyc(3);
    check("reset_pending", {28'd0, pending}, 32'd0);
    rst_n = 1'b1;
    step();
    check("first_toggle", {28'd0, clk_out}, 32'hF);
    cyc(3);

    // period change on ch0: N=3, then N=5 written mid-period
    cfg_write(0, 3);
    cyc(12);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_cnt[0] == 1) found = 1; else step();
    end
    check("mid_period_found", found, 1);
    cfg_write(0, 5);
    check("ch0_pending", {31'd0, pending[0]}, 32'd1);
    cyc(25);

    // collision on ch1: write N=2 on the terminal-count cycle of N=3
    cfg_write(1, 3);
    cyc(10);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_cnt[1] == m_act[1] - 1) found = 1; else step();
    end
    check("terminal_found", found, 1);
    cfg_write(1, 2);
    pc = 0;
    for (int k = 0; k < 10; k++) begin
      if (!pending[1]) break;
      pc++;
      step();
    end
    check("collision_pending_cycles", pc, 3);
    cyc(8);

    // zero half-period on ch2 behaves as 1
    cfg_write(2, 3);
    cyc(10);
    cfg_write(2, 0);
    cyc(10);

    // restart with N=2,3,4,7
    cfg_write(0, 2);
    cyc(2);
    cfg_write(1, 3);
    cfg_write(2, 4);
    cyc(1);
    cfg_write(3, 7);
    cyc(20);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    check("restart_clk_low", {28'd0, clk_out}, 32'd0);
    rise_scan(12);
    check("rise_ch0", rise[0], 2);
    check("rise_ch1", rise[1], 3);
    check("rise_ch2", rise[2], 4);
    check("rise_ch3", rise[3], 7);

    // restart applies pending ch3, same-cycle config on ch1 stays pending
    cfg_write(3, 2);
    sync_restart = 1'b1;
    cfg_write(1, 6);
    sync_restart = 1'b0;
    check("restart_cfg_pending", {28'd0, pending}, 32'h2);
    cyc(15);

    // drop en[3] with a staged value; it is applied while disabled
    cfg_write(3, 5);
    en = 4'h7;
    step();
    check("endrop_clk3", {31'd0, clk_out[3]}, 32'd0);
    check("endrop_pend3", {31'd0, pending[3]}, 32'd0);
    cyc(2);
    en = 4'hF;
    rise_scan(8);
    check("rise_after_en", rise[3], 5);

    // reset while a value is pending
    cfg_write(2, 6);
    check("pend_before_reset", {31'd0, pending[2]}, 32'd1);
    rst_n = 1'b0;
    step();
    check("reset_clears_pending", {28'd0, pending}, 32'd0);
    rst_n = 1'b1;
    cyc(4);

    // three-channel instance: cfg_ch=3 is accepted and ignored
    en3 = 3'h7; rst3_n = 1'b1;
    @(posedge clk_in); #1;
    check("d3_toggle1", {29'd0, clk_out3}, 32'h7);
    cfg3_if.cfg_valid = 1'b1; cfg3_if.cfg_ch = 2'd3; cfg3_if.cfg_half_period = 24'd5;
    #1;
    check("d3_ready", {31'd0, cfg3_if.cfg_ready}, 32'd1);
    @(posedge clk_in); #1;
    cfg3_if.cfg_valid = 1'b0;
    check("d3_pending", {29'd0, pending3}, 32'd0);
    check("d3_toggle2", {29'd0, clk_out3}, 32'd0);
    @(posedge clk_in); #1;
    check("d3_toggle3", {29'd0, clk_out3}, 32'h7);
    check("d3_pending2", {29'd0, pending3}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
